// File: rtl/sram_cfg_pkg.sv
// Shared types and constants for the SRAM configuration-cell controller.
package sram_cfg_pkg;

  localparam int unsigned DEFAULT_ROWS = 8;
  localparam int unsigned DEFAULT_COLS = 16;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    RD_PULSE,
    RESP
  } state_t;

endpackage

// File: rtl/sram_cfg_row_decoder.sv
// One-hot row strobe decode with complements; out-of-range rows decode to nothing.
module sram_cfg_row_decoder #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned AW   = 3
) (
  input  logic [AW-1:0]   addr,
  input  logic            wr_en,
  input  logic            rd_en,
  output logic [ROWS-1:0] write_c,
  output logic [ROWS-1:0] write_n_c,
  output logic [ROWS-1:0] read_c,
  output logic [ROWS-1:0] read_n_c
);

  logic            in_range_c;
  logic [ROWS-1:0] onehot_c;

  always_comb begin
    in_range_c = 32'(addr) < ROWS;
    onehot_c   = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      onehot_c[r] = in_range_c && (32'(addr) == r);
    end
    write_c   = wr_en ? onehot_c : '0;
    read_c    = rd_en ? onehot_c : '0;
    write_n_c = ~write_c;
    read_n_c  = ~read_c;
  end

endmodule

// File: rtl/sram_cfg_controller.sv
// Write/readback master for one column of SRAM configuration cells.
module sram_cfg_controller
  import sram_cfg_pkg::*;
#(
  parameter int unsigned ROWS = DEFAULT_ROWS,
  parameter int unsigned COLS = DEFAULT_COLS,
  parameter int unsigned AW   = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            io_cmdValid,
  output logic            io_cmdReady,
  input  logic            io_cmdOp,
  input  logic [AW-1:0]   io_cmdAddr,
  input  logic [COLS-1:0] io_cmdData,
  output logic            io_rspValid,
  input  logic            io_rspReady,
  output logic [COLS-1:0] io_rspData,
  output logic            io_rspErr,
  output logic [COLS-1:0] io_bitWrite,
  input  logic [COLS-1:0] io_bitRead,
  output logic [ROWS-1:0] io_write,
  output logic [ROWS-1:0] io_writeN,
  output logic [ROWS-1:0] io_read,
  output logic [ROWS-1:0] io_readN,
  output logic            io_busy
);

  state_t          state;
  state_t          next_state;
  logic [AW-1:0]   addr_q;
  logic            err_q;
  logic            accept_c;
  logic [AW-1:0]   dec_addr_c;
  logic            dec_wr_en_c;
  logic            dec_rd_en_c;
  logic [ROWS-1:0] dec_write_c;
  logic [ROWS-1:0] dec_write_n_c;
  logic [ROWS-1:0] dec_read_c;
  logic [ROWS-1:0] dec_read_n_c;

  assign accept_c = io_cmdValid && io_cmdReady;

  // Next state; strobes are decoded from the state being entered so they register on time.
  always_comb begin
    next_state  = state;
    dec_addr_c  = addr_q;
    dec_wr_en_c = 1'b0;
    dec_rd_en_c = 1'b0;
    unique case (state)
      IDLE: begin
        dec_addr_c = io_cmdAddr;
        if (accept_c) next_state = (io_cmdOp == OP_READ) ? RD_PULSE : WR_SETUP;
      end
      WR_SETUP: next_state = WR_PULSE;
      WR_PULSE: next_state = WR_HOLD;
      WR_HOLD:  next_state = IDLE;
      RD_PULSE: next_state = RESP;
      RESP:     if (io_rspReady) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    dec_wr_en_c = (next_state == WR_PULSE);
    dec_rd_en_c = (next_state == RD_PULSE);
  end

  sram_cfg_row_decoder #(
    .ROWS(ROWS),
    .AW  (AW)
  ) u_row_decoder (
    .addr     (dec_addr_c),
    .wr_en    (dec_wr_en_c),
    .rd_en    (dec_rd_en_c),
    .write_c  (dec_write_c),
    .write_n_c(dec_write_n_c),
    .read_c   (dec_read_c),
    .read_n_c (dec_read_n_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      err_q       <= 1'b0;
      io_cmdReady <= 1'b0;
      io_busy     <= 1'b0;
      io_rspValid <= 1'b0;
      io_rspData  <= '0;
      io_rspErr   <= 1'b0;
      io_bitWrite <= '0;
      io_write    <= '0;
      io_writeN   <= '1;
      io_read     <= '0;
      io_readN    <= '1;
    end else begin
      state       <= next_state;
      io_cmdReady <= (next_state == IDLE);
      io_busy     <= (next_state != IDLE);
      io_rspValid <= (next_state == RESP);
      io_write    <= dec_write_c;
      io_writeN   <= dec_write_n_c;
      io_read     <= dec_read_c;
      io_readN    <= dec_read_n_c;
      if (accept_c) begin
        addr_q <= io_cmdAddr;
        err_q  <= (32'(io_cmdAddr) >= ROWS);
        if (io_cmdOp == OP_WRITE) io_bitWrite <= io_cmdData;
      end
      // Cells drive the read lines only while strobed, so capture at the end of the pulse.
      if (state == RD_PULSE) begin
        io_rspData <= err_q ? '0 : io_bitRead;
        io_rspErr  <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_sram_cfg_controller.sv
// Bench for sram_cfg_controller: cell-array model, response scoreboard, timing checks.
module tb_sram_cfg_controller;
  import sram_cfg_pkg::*;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 16;
  localparam int unsigned AW    = 3;
  localparam int unsigned ROWS6 = 6;

  typedef struct packed {
    logic [COLS-1:0] data;
    logic            err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic            cmd_valid, cmd_ready, cmd_op, rsp_valid, rsp_ready, rsp_err, busy;
  logic [AW-1:0]   cmd_addr;
  logic [COLS-1:0] cmd_data, rsp_data, bit_write, bit_read;
  logic [ROWS-1:0] wr, wr_n, rd, rd_n;

  logic             o_cmd_valid, o_cmd_ready, o_cmd_op, o_rsp_valid, o_rsp_ready, o_rsp_err, o_busy;
  logic [AW-1:0]    o_cmd_addr;
  logic [COLS-1:0]  o_cmd_data, o_rsp_data, o_bit_write, o_bit_read;
  logic [ROWS6-1:0] o_wr, o_wr_n, o_rd, o_rd_n;

  sram_cfg_controller #(.ROWS(ROWS), .COLS(COLS)) u_dut (
    .clk(clk), .reset(reset),
    .io_cmdValid(cmd_valid), .io_cmdReady(cmd_ready), .io_cmdOp(cmd_op),
    .io_cmdAddr(cmd_addr), .io_cmdData(cmd_data),
    .io_rspValid(rsp_valid), .io_rspReady(rsp_ready), .io_rspData(rsp_data), .io_rspErr(rsp_err),
    .io_bitWrite(bit_write), .io_bitRead(bit_read),
    .io_write(wr), .io_writeN(wr_n), .io_read(rd), .io_readN(rd_n), .io_busy(busy)
  );

  sram_cfg_controller #(.ROWS(ROWS6), .COLS(COLS)) u_dut6 (
    .clk(clk), .reset(reset),
    .io_cmdValid(o_cmd_valid), .io_cmdReady(o_cmd_ready), .io_cmdOp(o_cmd_op),
    .io_cmdAddr(o_cmd_addr), .io_cmdData(o_cmd_data),
    .io_rspValid(o_rsp_valid), .io_rspReady(o_rsp_ready), .io_rspData(o_rsp_data), .io_rspErr(o_rsp_err),
    .io_bitWrite(o_bit_write), .io_bitRead(o_bit_read),
    .io_write(o_wr), .io_writeN(o_wr_n), .io_read(o_rd), .io_readN(o_rd_n), .io_busy(o_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int inv_viol = 0;
  int strobe_cnt [ROWS];
  logic strobe6_seen = 1'b0;
  rsp_t exp_q [$];
  rsp_t exp6_q [$];
  logic [COLS-1:0] shadow [ROWS];
  logic [COLS-1:0] cells [ROWS];

  always @(posedge clk) cyc <= cyc + 1;

  // Cell array model: strobed row latches the write lines, or drives the read lines.
  always @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) if (wr[r] === 1'b1) cells[r] <= bit_write;
  end
  always_comb begin
    bit_read = '0;
    for (int r = 0; r < ROWS; r++) if (rd[r] === 1'b1) bit_read = cells[r];
  end
  assign o_bit_read = '1;

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_n !== ~wr || rd_n !== ~rd || $countones({wr, rd}) > 1 ||
          o_wr_n !== ~o_wr || o_rd_n !== ~o_rd)
        inv_viol <= inv_viol + 1;
      for (int r = 0; r < ROWS; r++) if (wr[r] === 1'b1) strobe_cnt[r] <= strobe_cnt[r] + 1;
      if ((|o_wr) || (|o_rd)) strobe6_seen <= 1'b1;
    end
  end

  // Offers a command at a negedge; returns at the negedge after the accepting edge, valid left high.
  task automatic do_cmd(input logic op, input logic [AW-1:0] addr, input logic [COLS-1:0] data,
                        output int t_acc);
    int budget;
    budget = 20;
    t_acc = -1;
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    while (budget > 0) begin
      if (cmd_ready === 1'b1) begin
        t_acc = cyc;
        break;
      end
      @(negedge clk);
      budget--;
    end
    n_cmp++;
    if (t_acc < 0) begin
      n_bad++;
      $display("FAIL cmd_accept: no accept within 20 cycles (addr %0d)", addr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    cmd_valid = 0; cmd_op = 0; cmd_addr = '0; cmd_data = '0; rsp_ready = 0;
    o_cmd_valid = 0; o_cmd_op = 0; o_cmd_addr = '0; o_cmd_data = '0; o_rsp_ready = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: ready=%b busy=%b rspValid=%b, want 0 0 0", cmd_ready, busy, rsp_valid);
    end
    n_cmp++;
    if (wr !== '0 || wr_n !== {ROWS{1'b1}} || rd !== '0 || rd_n !== {ROWS{1'b1}}) begin
      n_bad++;
      $display("FAIL reset_strobes: w=%h wn=%h r=%h rn=%h, want 00 ff 00 ff", wr, wr_n, rd, rd_n);
    end
    n_cmp++;
    if (rsp_data !== '0 || rsp_err !== 1'b0 || bit_write !== '0) begin
      n_bad++;
      $display("FAIL reset_data: rspData=%h rspErr=%b bitWrite=%h, want 0", rsp_data, rsp_err, bit_write);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: ready=%b busy=%b ready6=%b, want 1 0 1", cmd_ready, busy, o_cmd_ready);
    end
  endtask

  task automatic test_write_readback();
    int t;
    logic [ROWS-1:0] ew;
    rsp_t e;
    rsp_ready = 1'b1;
    shadow[3] = 16'hA5C3;
    do_cmd(OP_WRITE, 3'd3, 16'hA5C3, t);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      ew = (k == 2) ? 8'h08 : 8'h00;
      n_cmp++;
      if (wr !== ew || wr_n !== ~ew || rd !== '0) begin
        n_bad++;
        $display("FAIL wr_strobe T+%0d: write=%h writeN=%h read=%h, want %h %h 00", k, wr, wr_n, rd, ew, ~ew);
      end
      n_cmp++;
      if (cmd_ready !== (k == 4)) begin
        n_bad++;
        $display("FAIL wr_ready T+%0d: ready=%b, want %b", k, cmd_ready, (k == 4));
      end
      if (k <= 3) begin
        n_cmp++;
        if (bit_write !== 16'hA5C3) begin
          n_bad++;
          $display("FAIL wr_bitwrite T+%0d: bitWrite=%h, want a5c3", k, bit_write);
        end
        @(negedge clk);
      end
    end
    exp_q.push_back('{data: shadow[3], err: 1'b0});
    do_cmd(OP_READ, 3'd3, '0, t);
    cmd_valid = 1'b0;
    n_cmp++;
    if (rd !== 8'h08 || rd_n !== 8'hF7 || wr !== '0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_strobe: read=%h readN=%h write=%h rspValid=%b, want 08 f7 00 0", rd, rd_n, wr, rsp_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL rd_rspvalid: rspValid=%b queued=%0d, want 1 and >0", rsp_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rsp_data !== e.data || rsp_err !== e.err) begin
        n_bad++;
        $display("FAIL rd_data: rspData=%h rspErr=%b, want %h %b", rsp_data, rsp_err, e.data, e.err);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_return: ready=%b rspValid=%b, want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int t, t_prev, budget;
    int base [ROWS];
    logic [COLS-1:0] d;
    rsp_t e;
    t_prev = 0;
    for (int r = 0; r < ROWS; r++) base[r] = strobe_cnt[r];
    for (int r = 0; r < ROWS; r++) begin
      d = COLS'($urandom);
      shadow[r] = d;
      do_cmd(OP_WRITE, AW'(r), d, t);
      if (r > 0) begin
        n_cmp++;
        if (t - t_prev != 4) begin
          n_bad++;
          $display("FAIL b2b_spacing row %0d: accept gap=%0d, want 4", r, t - t_prev);
        end
      end
      t_prev = t;
    end
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int r = 0; r < ROWS; r++) begin
      n_cmp++;
      if (strobe_cnt[r] - base[r] != 1) begin
        n_bad++;
        $display("FAIL b2b_strobe_count row %0d: strobes=%0d, want 1", r, strobe_cnt[r] - base[r]);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      exp_q.push_back('{data: shadow[r], err: 1'b0});
      do_cmd(OP_READ, AW'(r), '0, t);
      cmd_valid = 1'b0;
      budget = 10;
      while (rsp_valid !== 1'b1 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      n_cmp++;
      if (rsp_valid !== 1'b1 || exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL b2b_rsp row %0d: rspValid=%b queued=%0d, want 1 and >0", r, rsp_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e.data || rsp_err !== e.err) begin
          n_bad++;
          $display("FAIL b2b_readback row %0d: rspData=%h rspErr=%b, want %h %b", r, rsp_data, rsp_err, e.data, e.err);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int t;
    rsp_t e;
    rsp_ready = 1'b1;
    shadow[6] = 16'h3C5A;
    do_cmd(OP_WRITE, 3'd6, 16'h3C5A, t);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    exp_q.push_back('{data: shadow[6], err: 1'b0});
    do_cmd(OP_READ, 3'd6, '0, t);
    cmd_valid = 1'b0;
    @(negedge clk);
    e = exp_q[0];
    for (int k = 0; k < 10; k++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err || cmd_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold cycle %0d: rspValid=%b rspData=%h rspErr=%b ready=%b, want 1 %h %b 0",
                 k, rsp_valid, rsp_data, rsp_err, cmd_ready, e.data, e.err);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: rspValid=%b, want 1", rsp_valid);
    end else begin
      e = exp_q.pop_front();
      if (rsp_data !== e.data) begin
        n_bad++;
        $display("FAIL bp_release: rspData=%h, want %h", rsp_data, e.data);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_after: ready=%b rspValid=%b, want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    int t;
    do_cmd(OP_WRITE, 3'd5, 16'h1234, t);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (wr !== 8'h20) begin
      n_bad++;
      $display("FAIL midrst_pulse: write=%h, want 20", wr);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (wr !== '0 || wr_n !== {ROWS{1'b1}} || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_async: write=%h writeN=%h busy=%b ready=%b, want 00 ff 0 0", wr, wr_n, busy, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || wr !== '0) begin
      n_bad++;
      $display("FAIL midrst_release: ready=%b busy=%b rspValid=%b write=%h, want 1 0 0 00",
               cmd_ready, busy, rsp_valid, wr);
    end
  endtask

  task automatic test_out_of_range();
    int budget, cycles;
    rsp_t e;
    o_rsp_ready = 1'b1;
    o_cmd_op = OP_WRITE; o_cmd_addr = 3'd7; o_cmd_data = 16'hBEEF; o_cmd_valid = 1'b1;
    budget = 20;
    while (o_cmd_ready !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
    @(negedge clk);
    o_cmd_valid = 1'b0;
    n_cmp++;
    if (o_busy !== 1'b1 || o_bit_write !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL oor_wr_accept: busy=%b bitWrite=%h, want 1 beef", o_busy, o_bit_write);
    end
    cycles = 0;
    while (o_cmd_ready !== 1'b1 && cycles < 20) begin @(negedge clk); cycles++; end
    n_cmp++;
    if (cycles != 3) begin
      n_bad++;
      $display("FAIL oor_wr_sequence: ready after %0d more cycles, want 3", cycles);
    end
    exp6_q.push_back('{data: '0, err: 1'b1});
    o_cmd_op = OP_READ; o_cmd_addr = 3'd7; o_cmd_valid = 1'b1;
    @(negedge clk);
    o_cmd_valid = 1'b0;
    budget = 10;
    while (o_rsp_valid !== 1'b1 && budget > 0) begin @(negedge clk); budget--; end
    n_cmp++;
    if (o_rsp_valid !== 1'b1 || exp6_q.size() == 0) begin
      n_bad++;
      $display("FAIL oor_rsp: rspValid=%b queued=%0d, want 1 and >0", o_rsp_valid, exp6_q.size());
    end else begin
      e = exp6_q.pop_front();
      if (o_rsp_data !== e.data || o_rsp_err !== e.err) begin
        n_bad++;
        $display("FAIL oor_rsp: rspData=%h rspErr=%b, want %h %b", o_rsp_data, o_rsp_err, e.data, e.err);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (strobe6_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_strobe: strobe seen=%b, want 0", strobe6_seen);
    end
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (inv_viol != 0) begin
      n_bad++;
      $display("FAIL strobe_invariants: %0d violating cycles, want 0", inv_viol);
    end
    n_cmp++;
    if (exp_q.size() != 0 || exp6_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d/%0d responses outstanding, want 0", exp_q.size(), exp6_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    test_out_of_range();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_cfg_controller.md
# sram_cfg_controller

Controller for a column of SRAM configuration cells: the write/readback master for the cell array. It accepts write and readback commands over a valid/ready interface, drives the shared write-data bit lines and the per-row complementary write/read strobes, samples the cells' tristated readback lines and returns readback words over a valid/ready response channel. It sits between the bitstream loader and the configuration array of one fabric tile.

## Interface
- ROWS, 8, number of word rows (cells per bit line); 2..256
- COLS, 16, word width (bit lines); 1..64
- AW, clog2(ROWS), row address width
- clk  in  1  sole clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high
- io_cmdValid  in  1  command offered
- io_cmdReady  out  1  command accepted when Valid&&Ready
- io_cmdOp  in  1  0 = write, 1 = readback
- io_cmdAddr  in  AW  target row
- io_cmdData  in  COLS  write data; ignored for readback
- io_rspValid  out  1  readback word available
- io_rspReady  in  1  consumer accepts response
- io_rspData  out  COLS  readback word
- io_rspErr  out  1  response belongs to an out-of-range address
- io_bitWrite  out  COLS  shared write-data bit lines
- io_bitRead  in  COLS  shared readback bit lines (high-Z except during a read strobe)
- io_write, io_writeN  out  ROWS  per-row write strobe and its complement
- io_read, io_readN  out  ROWS  per-row read strobe and its complement
- io_busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_PULSE, RESP.
- IDLE: io_cmdReady=1. Accepting a write latches addr/data and goes to WR_SETUP; accepting a readback latches addr and goes to RD_PULSE.
- WR_SETUP: io_bitWrite = latched data; all strobes inactive. Next is WR_PULSE.
- WR_PULSE: io_write[addr]=1 and io_writeN[addr]=0 for exactly one cycle; data held. Next is WR_HOLD.
- WR_HOLD: strobes inactive; data held. Next is IDLE.
- RD_PULSE: io_read[addr]=1 and io_readN[addr]=0 for one cycle. io_bitRead is registered into io_rspData at the end of this cycle. Next is RESP.
- RESP: io_rspValid=1 with io_rspData/io_rspErr stable. Leaves to IDLE on io_rspReady.
- Complement invariant, in every cycle including reset: io_writeN == ~io_write and io_readN == ~io_read.
- At most one row strobe is asserted at any time. Write and read strobes are never asserted in the same cycle.
- Out-of-range address (addr >= ROWS):
  - Write: accepted, sequenced through all states with no strobe asserted.
  - Readback: no strobe asserted; RESP carries rspData=0 and rspErr=1.
- io_bitWrite holds its last driven value outside the write sequence. It is 0 after reset.

## Timing
- Reset values: io_cmdReady=0 while reset is asserted and 1 after release; io_rspValid=0, io_rspData=0, io_rspErr=0, io_bitWrite=0, io_write=0, io_read=0, io_writeN=all ones, io_readN=all ones, io_busy=0; FSM in IDLE.
- Write accepted at edge T: strobe active during cycle T+2; cmdReady returns in cycle T+4. Throughput is one write per 4 cycles.
- Readback accepted at edge T: strobe active during cycle T+1; io_rspValid=1 from cycle T+2. With io_rspReady held high, cmdReady returns in cycle T+3.
- io_rspValid stays high and io_rspData stays stable until the handshake; backpressure is unlimited.
- Reset asserted mid-operation: every strobe deasserts immediately (asynchronously) and any pending response is discarded.

## Structure
- Package sram_cfg_pkg holds:
  - the state enum;
  - op encodings OP_WRITE=0 and OP_READ=1;
  - default ROWS/COLS constants.
- Sub-module sram_cfg_row_decoder:
  - inputs: addr, wr_en, rd_en;
  - outputs: the one-hot write/read vectors and their complements, forced inactive when addr >= ROWS.
- Every strobe output is a registered output.

## Test plan
- Reset check: assert reset mid-WR_PULSE -> in the same cycle io_write=0, io_writeN=all ones, io_busy=0; after release cmdReady=1.
- Write, then readback: write row 3 with 0xA5C3 and model the cell array -> io_write=0x08 for exactly one cycle with bitWrite=0xA5C3 stable from T+1 to T+3. Readback of row 3 -> rspData=0xA5C3, rspErr=0.
- Back-to-back writes: writes to rows 0..7 with cmdValid held high -> one accept every 4 cycles; each row strobed once; never two strobe bits set together.
- Response backpressure: readback with rspReady low for 10 cycles -> rspValid and rspData stable throughout; cmdReady stays 0 until the handshake.
- Out-of-range (ROWS=6): write and readback to addr 7 -> no strobe ever asserted; response rspData=0, rspErr=1.
